// File: rtl/robs_mult_arbiter.sv
// Round-robin front end sharing one sequential signed multiplier among NREQ clients.
// One operation in flight at a time; a watchdog turns a missing done into an error response.
module robs_mult_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_multiplier,
  input  logic [NREQ*WIDTH-1:0]   req_multiplicand,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [2*WIDTH-1:0]      resp_product,
  output logic                    resp_err,
  output logic                    mult_start,
  output logic [WIDTH-1:0]        mult_multiplier,
  output logic [WIDTH-1:0]        mult_multiplicand,
  input  logic [2*WIDTH-1:0]      mult_product,
  input  logic                    mult_done
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WDW  = $clog2(TIMEOUT + 1);
  localparam int unsigned PW   = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

  state_e           state_q;
  logic [IDXW-1:0]  ptr_q;
  logic [IDXW-1:0]  owner_q;
  logic [WIDTH-1:0] mplr_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WDW-1:0]   wdog_q;
  logic [NREQ-1:0]  resp_valid_q;
  logic [PW-1:0]    resp_product_q;
  logic             resp_err_q;

  logic [IDXW-1:0]  grant_idx;
  logic [IDXW-1:0]  cand;
  logic             grant_found;
  logic [NREQ-1:0]  grant_oh;
  logic [WIDTH-1:0] req_mplr  [NREQ];
  logic [WIDTH-1:0] req_mcand [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign req_mplr[gi]  = req_multiplier[gi*WIDTH +: WIDTH];
    assign req_mcand[gi] = req_multiplicand[gi*WIDTH +: WIDTH];
  end

  // First valid requester after the last owner, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    cand        = ptr_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDXW'((32'(ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_oh          = NREQ'(1) << grant_idx;
  assign req_ready         = (state_q == S_IDLE && grant_found) ? grant_oh : '0;
  assign mult_start        = reset | (state_q == S_LAUNCH);
  assign mult_multiplier   = mplr_q;
  assign mult_multiplicand = mcand_q;
  assign resp_valid        = resp_valid_q;
  assign resp_product      = resp_product_q;
  assign resp_err          = resp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= IDXW'(NREQ - 1);
      owner_q        <= '0;
      mplr_q         <= '0;
      mcand_q        <= '0;
      wdog_q         <= '0;
      resp_valid_q   <= '0;
      resp_product_q <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            mplr_q  <= req_mplr[grant_idx];
            mcand_q <= req_mcand[grant_idx];
            owner_q <= grant_idx;
            ptr_q   <= grant_idx;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + WDW'(1);
          // A done seen in the first WAIT cycle belongs to the previous operation.
          if (wdog_q != '0 && mult_done) begin
            resp_product_q <= mult_product;
            resp_err_q     <= 1'b0;
            resp_valid_q   <= NREQ'(1) << owner_q;
            state_q        <= S_RESP;
          end else if (wdog_q + WDW'(1) == WDW'(TIMEOUT)) begin
            resp_product_q <= '0;
            resp_err_q     <= 1'b1;
            resp_valid_q   <= NREQ'(1) << owner_q;
            state_q        <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready[owner_q]) begin
            resp_valid_q <= '0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/robs_mult_arbiter.md
Name: robs_mult_arbiter

Overview:
- Round-robin scheduler that shares one Robertson sequential multiplier (WIDTH-bit signed operands, 2*WIDTH-bit product, done flag) among NREQ requesters.
- Per requester: accepts operand pairs over valid/ready, latches them, restarts the multiplier with a one-cycle start pulse, waits for done (with watchdog), returns the product to the granted requester over valid/ready.
- Sits between client blocks and the multiplier instance at the top level; the multiplier's reset input is driven by mult_start.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum WAIT cycles before the operation is abandoned with an error.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has operands pending.
- req_ready  out  NREQ  one-hot accept strobe; handshake when req_valid[i] & req_ready[i].
- req_multiplier  in  NREQ*WIDTH  packed; slice i = [i*WIDTH +: WIDTH].
- req_multiplicand  in  NREQ*WIDTH  packed, same slicing.
- resp_valid  out  NREQ  one-hot, result available for requester i.
- resp_ready  in  NREQ  requester i consumes result.
- resp_product  out  2*WIDTH  signed product of the owning request.
- resp_err  out  1  qualifies resp_valid: 1 = watchdog expired, resp_product = 0.
- mult_start  out  1  drives multiplier reset; starts a new multiply.
- mult_multiplier  out  WIDTH  latched operand to multiplier.
- mult_multiplicand  out  WIDTH  latched operand to multiplier.
- mult_product  in  2*WIDTH  multiplier result.
- mult_done  in  1  multiplier result valid.

Behaviour:
- States: IDLE, LAUNCH, WAIT, RESP. Reset: state=IDLE, req_ready=0, resp_valid=0, resp_product=0, resp_err=0, operand regs=0, watchdog=0, rr pointer=NREQ-1 (requester 0 has top priority first).
- mult_start = reset | (state==LAUNCH). Multiplier is held in reset while the arbiter is in reset.
- IDLE:
  - Grant g = first i with req_valid[i], searched from (ptr+1) mod NREQ upward with wrap.
  - req_ready is combinational, one-hot at g, only in IDLE; all zero if no request is valid.
  - On handshake: latch operands of g, owner<=g, ptr<=g, go to LAUNCH.
- LAUNCH (exactly 1 cycle): mult_start=1, watchdog<=0, go to WAIT.
- WAIT:
  - mult_done is ignored in the first WAIT cycle (stale done from the previous op).
  - From the second cycle on, mult_done=1: resp_product<=mult_product, resp_err<=0, go to RESP.
  - Watchdog increments each WAIT cycle. If it reaches TIMEOUT without done: resp_product<=0, resp_err<=1, go to RESP.
  - Done and expiry in the same cycle: done wins.
- RESP:
  - resp_valid[owner]=1. resp_product and resp_err stay stable until resp_ready[owner]=1, then go to IDLE.
  - resp_ready of non-owners is ignored.
- Latency: accept at cycle T, mult_start at T+1, WAIT from T+2, resp_valid the cycle after done is sampled. Earliest next accept is the cycle after the response handshake (one op in flight).
- mult_multiplier / mult_multiplicand hold the latched values from LAUNCH until the next accept.
- Requesters that drop req_valid before grant are not served; no state is kept for them.
- Reset mid-operation (any state) returns all outputs to reset values next cycle; the in-flight result is discarded and no response is issued.

Test Plan:
- Single request: req 1, multiplier=3, multiplicand=5 -> req_ready[1] one cycle, mult_start pulse one cycle later, resp_valid=4'b0010, resp_product=16'h000F, resp_err=0.
- Signed operands: req 0, multiplier=7, multiplicand=8'hFD (-3) -> resp_product=16'hFFEB, resp_err=0.
- Round-robin fairness: all four req_valid held high, resp_ready all high -> grant order 0,1,2,3,0,1; each requester's own product is returned.
- Backpressure: req 2 done, resp_ready[2]=0 for 10 cycles with resp_ready[0]=1 -> resp_valid[2] and product stable throughout; no new req_ready until resp_ready[2]=1.
- Watchdog: mult_done tied 0, req 3 -> after 64 WAIT cycles resp_valid[3]=1, resp_err=1, resp_product=0.
- Reset mid-WAIT: assert reset 1 cycle during WAIT -> next cycle state IDLE, resp_valid=0, mult_start=1 during reset; a pending req 0 is granted first afterwards.
